// File: rtl/vga_pkg.sv
// Shared VGA timing types and the standard 640x480@60 preset.
package vga_pkg;

    typedef struct packed {
        int visible;
        int fp;
        int sync;
        int bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h: '{visible: 640, fp: 16, sync: 96, bp: 48},
        v: '{visible: 480, fp: 10, sync: 2,  bp: 33}
    };

    function automatic int axis_total(input vga_axis_t a);
        return a.visible + a.fp + a.sync + a.bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay with synchronous clear; depth 0 is a plain wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused;
        assign unused = &{1'b0, clk, clr};
        assign q = d;
    end else begin : g_pipe
        logic [DEPTH-1:0][WIDTH-1:0] pipe;

        always_ff @(posedge clk) begin
            if (clr) begin
                pipe <= '0;
            end else begin
                pipe[0] <= d;
                for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign q = pipe[DEPTH-1];
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA raster generator: scans a scaled frame buffer and emits colour, syncs and
// blanking aligned to the frame-buffer read latency.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int SCALE_LOG2 = 1,
    parameter int RD_LAT     = 1,
    parameter int MONOCHROME = 1,
    parameter int ADDR_W     = 17,
    localparam int DATA_W    = (MONOCHROME != 0) ? 8 : 24
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              vga_sync_n,
    output logic              frame_start
);

    localparam vga_timing_t TIM = '{
        h: '{visible: H_VISIBLE, fp: H_FP, sync: H_SYNC, bp: H_BP},
        v: '{visible: V_VISIBLE, fp: V_FP, sync: V_SYNC, bp: V_BP}
    };
    localparam int H_TOTAL  = axis_total(TIM.h);
    localparam int V_TOTAL  = axis_total(TIM.v);
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int H_SCALED = H_VISIBLE >> SCALE_LOG2;
    localparam int V_SCALED = V_VISIBLE >> SCALE_LOG2;

    if ((H_VISIBLE % (1 << SCALE_LOG2)) != 0 || (V_VISIBLE % (1 << SCALE_LOG2)) != 0) begin : g_bad_scale
        $error("vga_scanout: visible size not divisible by the scale factor");
    end
    if (longint'(H_SCALED) * longint'(V_SCALED) > (64'd1 << ADDR_W)) begin : g_bad_addr
        $error("vga_scanout: scaled frame does not fit in ADDR_W");
    end
    if (RD_LAT < 0 || RD_LAT > 4) begin : g_bad_lat
        $error("vga_scanout: RD_LAT out of range 0..4");
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last, v_last;
    logic          active, hs_raw, vs_raw, fs_raw;
    logic          act_d, hs_d, vs_d, fs_d;
    logic [7:0]    pix_r, pix_g, pix_b;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Stage 0: everything here is a pure function of the counters.
    assign active  = (h_cnt < HW'(H_VISIBLE)) && (v_cnt < VW'(V_VISIBLE));
    assign hs_raw  = (h_cnt >= HW'(H_VISIBLE + H_FP)) && (h_cnt <= HW'(H_VISIBLE + H_FP + H_SYNC - 1));
    assign vs_raw  = (v_cnt >= VW'(V_VISIBLE + V_FP)) && (v_cnt <= VW'(V_VISIBLE + V_FP + V_SYNC - 1));
    assign fs_raw  = (h_cnt == '0) && (v_cnt == '0);
    assign rd_en   = active & ~rst;
    assign rd_addr = ADDR_W'(v_cnt >> SCALE_LOG2) * ADDR_W'(H_SCALED) + ADDR_W'(h_cnt >> SCALE_LOG2);

    // Timing flags ride alongside the memory read so they meet rd_data together.
    vga_delay_line #(
        .WIDTH (4),
        .DEPTH (RD_LAT)
    ) u_dly (
        .clk (clk),
        .clr (rst),
        .d   ({fs_raw, vs_raw, hs_raw, active}),
        .q   ({fs_d, vs_d, hs_d, act_d})
    );

    if (MONOCHROME != 0) begin : g_mono
        assign pix_r = rd_data;
        assign pix_g = rd_data;
        assign pix_b = rd_data;
    end else begin : g_rgb
        assign pix_r = rd_data[23:16];
        assign pix_g = rd_data[15:8];
        assign pix_b = rd_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_blank_n <= 1'b0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= act_d ? pix_r : 8'h00;
            vga_g       <= act_d ? pix_g : 8'h00;
            vga_b       <= act_d ? pix_b : 8'h00;
            vga_blank_n <= act_d;
            vga_hs      <= hs_d ? HS_POL : ~HS_POL;
            vga_vs      <= vs_d ? VS_POL : ~VS_POL;
            frame_start <= fs_d;
        end
    end

    assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// Three scanout configurations (defaults, small scaled RD_LAT=2, small RGB
// active-high syncs RD_LAT=0) checked every clock against a raster-position model.
module tb_vga_scanout;
    import vga_pkg::*;

    localparam vga_timing_t SM = '{
        h: '{visible: 16, fp: 2, sync: 3, bp: 3},
        v: '{visible: 8,  fp: 1, sync: 2, bp: 1}
    };

    logic clk, rst;
    int   n, last_fs, total, bad;
    bit [7:0] key;
    bit   const_mode;
    logic [23:0] rgb_mem [128];

    logic        def_en, def_hs, def_vs, def_bn, def_sn, def_fs;
    logic [16:0] def_addr;
    logic [7:0]  def_data, def_r, def_g, def_b;

    logic        sm_en, sm_hs, sm_vs, sm_bn, sm_sn, sm_fs;
    logic [5:0]  sm_addr, sm_a1, sm_a2;
    logic [7:0]  sm_data, sm_r, sm_g, sm_b;

    logic        rgb_en, rgb_hs, rgb_vs, rgb_bn, rgb_sn, rgb_fs;
    logic [6:0]  rgb_addr;
    logic [23:0] rgb_data;
    logic [7:0]  rgb_r, rgb_g, rgb_b;

    vga_scanout u_def (
        .clk(clk), .rst(rst), .rd_en(def_en), .rd_addr(def_addr), .rd_data(def_data),
        .vga_r(def_r), .vga_g(def_g), .vga_b(def_b), .vga_hs(def_hs), .vga_vs(def_vs),
        .vga_blank_n(def_bn), .vga_sync_n(def_sn), .frame_start(def_fs)
    );

    vga_scanout #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SCALE_LOG2(1), .RD_LAT(2), .ADDR_W(6)
    ) u_sm (
        .clk(clk), .rst(rst), .rd_en(sm_en), .rd_addr(sm_addr), .rd_data(sm_data),
        .vga_r(sm_r), .vga_g(sm_g), .vga_b(sm_b), .vga_hs(sm_hs), .vga_vs(sm_vs),
        .vga_blank_n(sm_bn), .vga_sync_n(sm_sn), .frame_start(sm_fs)
    );

    vga_scanout #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .SCALE_LOG2(0), .RD_LAT(0),
        .MONOCHROME(0), .ADDR_W(7)
    ) u_rgb (
        .clk(clk), .rst(rst), .rd_en(rgb_en), .rd_addr(rgb_addr), .rd_data(rgb_data),
        .vga_r(rgb_r), .vga_g(rgb_g), .vga_b(rgb_b), .vga_hs(rgb_hs), .vga_vs(rgb_vs),
        .vga_blank_n(rgb_bn), .vga_sync_n(rgb_sn), .frame_start(rgb_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-buffer models with the configured read latencies.
    always @(posedge clk) def_data <= def_addr[7:0] ^ key;
    always @(posedge clk) begin
        sm_a1 <= sm_addr;
        sm_a2 <= sm_a1;
    end
    assign sm_data  = {2'b00, sm_a2};
    assign rgb_data = const_mode ? 24'hA55A3C : rgb_mem[rgb_addr];

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // n = clocks since reset release; scan position n is on the counters,
    // position n-lat-1 is on the outputs.
    task automatic geom(input string tag, input vga_timing_t t, input int lat, input int s,
                        input bit hp, input bit vp, input logic en, input logic [31:0] addr,
                        input logic bn, input logic hs, input logic vs, input logic fs,
                        output bit act, output int oaddr);
        int ht, vt, h, v, p;
        bit a0, hsa, vsa, fsa;
        ht = t.h.visible + t.h.fp + t.h.sync + t.h.bp;
        vt = t.v.visible + t.v.fp + t.v.sync + t.v.bp;
        h = n % ht;
        v = (n / ht) % vt;
        a0 = !rst && h < t.h.visible && v < t.v.visible;
        cmp({tag, ".rd_en"}, 32'(en), 32'(a0));
        if (a0) cmp({tag, ".rd_addr"}, addr, 32'((v >> s) * (t.h.visible >> s) + (h >> s)));
        p = n - lat - 1;
        act = 0; oaddr = 0; hsa = 0; vsa = 0; fsa = 0;
        if (p >= 0) begin
            h = p % ht;
            v = (p / ht) % vt;
            act = h < t.h.visible && v < t.v.visible;
            hsa = h >= t.h.visible + t.h.fp && h < t.h.visible + t.h.fp + t.h.sync;
            vsa = v >= t.v.visible + t.v.fp && v < t.v.visible + t.v.fp + t.v.sync;
            fsa = (h == 0) && (v == 0);
            oaddr = (v >> s) * (t.h.visible >> s) + (h >> s);
        end
        cmp({tag, ".blank_n"}, 32'(bn), 32'(act));
        cmp({tag, ".hs"}, 32'(hs), 32'(hsa ? hp : !hp));
        cmp({tag, ".vs"}, 32'(vs), 32'(vsa ? vp : !vp));
        cmp({tag, ".frame_start"}, 32'(fs), 32'(fsa));
    endtask

    task automatic check_all();
        bit act;
        int oa;
        logic [7:0]  e8;
        logic [23:0] e24;
        geom("def", VGA_640X480_60, 1, 1, 1'b0, 1'b0, def_en, 32'(def_addr),
             def_bn, def_hs, def_vs, def_fs, act, oa);
        e8 = act ? (8'(oa) ^ key) : 8'h00;
        cmp("def.r", 32'(def_r), 32'(e8));
        cmp("def.g", 32'(def_g), 32'(e8));
        cmp("def.b", 32'(def_b), 32'(e8));
        cmp("def.sync_n", 32'(def_sn), 32'd0);

        geom("sm", SM, 2, 1, 1'b0, 1'b0, sm_en, 32'(sm_addr),
             sm_bn, sm_hs, sm_vs, sm_fs, act, oa);
        e8 = act ? 8'(oa) : 8'h00;
        cmp("sm.r", 32'(sm_r), 32'(e8));
        cmp("sm.g", 32'(sm_g), 32'(e8));
        cmp("sm.b", 32'(sm_b), 32'(e8));

        geom("rgb", SM, 0, 0, 1'b1, 1'b1, rgb_en, 32'(rgb_addr),
             rgb_bn, rgb_hs, rgb_vs, rgb_fs, act, oa);
        e24 = act ? (const_mode ? 24'hA55A3C : rgb_mem[oa]) : 24'h0;
        cmp("rgb.r", 32'(rgb_r), 32'(e24[23:16]));
        cmp("rgb.g", 32'(rgb_g), 32'(e24[15:8]));
        cmp("rgb.b", 32'(rgb_b), 32'(e24[7:0]));
        cmp("rgb.sync_n", 32'(rgb_sn), 32'd0);

        if (!rst && n == 2) cmp("def.fs_at_T0+2", 32'(def_fs), 32'd1);
        if (!rst && n == 3 * 800 + 2) cmp("def.addr_2_3", 32'(def_addr), 32'd321);
        if (!rst && n % 800 == 640) cmp("def.rd_en_h640", 32'(def_en), 32'd0);
        if (!rst && n % 288 == 7 * 24 + 15) cmp("sm.addr_last", 32'(sm_addr), 32'd31);
        if (sm_fs === 1'b1) begin
            if (last_fs >= 0) cmp("sm.frame_period", 32'(n - last_fs), 32'd288);
            last_fs = n;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            n = 0;
            last_fs = -1;
        end else begin
            n++;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        total = 0; bad = 0; n = 0; last_fs = -1;
        key = 8'($urandom);
        const_mode = 1'b0;
        for (int i = 0; i < 128; i++) rgb_mem[i] = 24'($urandom);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2600) tick();

        // mid-frame reset at a random point, held a random number of clocks
        repeat ($urandom_range(0, 300)) tick();
        rst = 1'b1;
        tick();
        cmp("def.blank_after_rst", 32'(def_bn), 32'd0);
        repeat ($urandom_range(0, 2)) tick();
        rst = 1'b0;
        repeat (700) tick();

        const_mode = 1'b1;
        repeat (600) tick();
        const_mode = 1'b0;

        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(50, 400)) tick();
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            rst = 1'b0;
        end
        repeat (400) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters HS_POL / VS_POL, default 0 / 0, asserted sync level (0 = active-low).
REQ-006 SHALL have parameter SCALE_LOG2, default 1, pixel replication factor 2^SCALE_LOG2 in both axes.
REQ-007 SHALL have parameter RD_LAT, default 1, range 0..4, frame-buffer read latency in clocks.
REQ-008 SHALL have parameter MONOCHROME, default 1; DATA_W = 8 if 1, else 24 ({R,G,B}).
REQ-009 SHALL have parameter ADDR_W, default 17, read-address width.
REQ-010 clk  in  1  pixel clock; single clock domain.
REQ-011 rst  in  1  synchronous, active-high reset.
REQ-012 rd_en  out  1  frame-buffer read strobe.
REQ-013 rd_addr  out  ADDR_W  frame-buffer read address.
REQ-014 rd_data  in  DATA_W  frame-buffer data, valid RD_LAT clocks after rd_en.
REQ-015 vga_r / vga_g / vga_b  out  8 each  colour outputs.
REQ-016 vga_hs / vga_vs  out  1 each  sync outputs at HS_POL / VS_POL.
REQ-017 vga_blank_n  out  1  high in the active region; vga_sync_n  out  1  constant 0.
REQ-018 frame_start  out  1  one-clock pulse aligned with output pixel (0,0).

Function
REQ-019 h_cnt SHALL count 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1, where H_TOTAL = sum of the horizontal params and V_TOTAL = sum of the vertical params; h_cnt advances every clock.
REQ-020 At h_cnt = H_TOTAL-1, h_cnt SHALL wrap to 0 and v_cnt SHALL increment; if v_cnt = V_TOTAL-1 at the same time, both SHALL wrap to 0.
REQ-021 active SHALL equal (h_cnt < H_VISIBLE) and (v_cnt < V_VISIBLE); rd_en SHALL equal active, combinationally from the counters (stage 0).
REQ-022 rd_addr SHALL equal (v_cnt>>SCALE_LOG2)*(H_VISIBLE>>SCALE_LOG2) + (h_cnt>>SCALE_LOG2); it is don't-care while rd_en = 0.
REQ-023 hs_raw SHALL be asserted for h_cnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1].
REQ-024 vs_raw SHALL be asserted for whole lines with v_cnt in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1].
REQ-025 active, hs_raw, vs_raw and frame_start_raw (h_cnt = 0 and v_cnt = 0) SHALL pass through RD_LAT delay stages, then one output register stage.
REQ-026 Total latency from counter value to outputs SHALL be RD_LAT+1 clocks.
REQ-027 The output register SHALL capture rd_data when the delayed active = 1, else 0.
REQ-028 With MONOCHROME = 1, rd_data SHALL drive all three colours; with MONOCHROME = 0, vga_r = rd_data[23:16], vga_g = rd_data[15:8], vga_b = rd_data[7:0].
REQ-029 Elaboration SHALL fail unless all of the following hold: H_VISIBLE and V_VISIBLE are divisible by 2^SCALE_LOG2; the scaled frame size is at most 2^ADDR_W; RD_LAT is within 0..4.

Reset
REQ-030 While rst = 1, the following SHALL hold: h_cnt = v_cnt = 0; all delay stages are cleared to blanking; rd_en = 0.
REQ-031 Outputs during reset SHALL be: vga_r/g/b = 0; vga_blank_n = 0; vga_hs = ~HS_POL; vga_vs = ~VS_POL; frame_start = 0.
REQ-032 A reset asserted mid-frame SHALL take effect at the next clock edge; after release, scanning SHALL restart at (0,0), with frame_start on the RD_LAT+1-th clock.

Structure
REQ-033 Package vga_pkg SHALL hold the vga_timing_t struct (visible/fp/sync/bp per axis) and a localparam preset VGA_640X480_60.
REQ-034 Sub-module vga_delay_line (parametrised width and depth, depth 0 = wire, synchronous clear) SHALL implement the REQ-025 stages.

Verification
REQ-035 Default params, rst released at T0 -> frame_start high at T0+2; consecutive frame_start pulses exactly 420000 clocks apart.
REQ-036 Defaults -> in each line, vga_hs low for exactly 96 clocks, starting 656 clocks after the line's first output pixel; vga_vs low for output lines 490-491 only.
REQ-037 SCALE_LOG2 = 1 -> rd_addr = 321 at (h=2, v=3) and 76799 at (639, 479); rd_en = 0 at h = 640.
REQ-038 RD_LAT = 2, memory model returning rd_data = rd_addr[7:0] -> the outputs SHALL satisfy all of: vga_r = expected address byte on every active pixel; vga_r = 0 while vga_blank_n = 0; vga_g = vga_b = vga_r.
REQ-039 rst pulsed at (300, 200) -> outputs reach blanking values the next clock; after release, first frame_start at RD_LAT+1 clocks.
REQ-040 MONOCHROME = 0, HS_POL = 1, rd_data = 24'hA55A3C -> the outputs SHALL satisfy all of: vga_r = A5, vga_g = 5A, vga_b = 3C; vga_hs high only during the sync window.
